// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and controller state encoding for the divided-clock generator
package clk_div_pkg;
    localparam int WIDTH = 28;
    localparam logic [WIDTH-1:0] DEFAULT_DIV = 28'd1000;
    localparam logic [WIDTH-1:0] MIN_DIV = 28'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;
endpackage

// File: rtl/clk_div_if.sv
// rtl/clk_div_if.sv - run/config request and divided-clock status bundle
interface clk_div_if #(
    parameter int WIDTH = clk_div_pkg::WIDTH
) ();
    logic             en;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [WIDTH-1:0] cur_div;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, clk_out, tick, running, cur_div
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, clk_out, tick, running, cur_div
    );
endinterface

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter with registered divided clock, tick strobe and divisor register
module clk_div_core #(
    parameter int               WIDTH       = clk_div_pkg::WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clkold,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    output logic             wrap,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] counter;

    assign wrap = (counter >= cur_div - ONE);

    // clk_out is judged on the pre-update count, so it trails the counter by one edge
    always_ff @(posedge clkold or posedge rst) begin
        if (rst) begin
            counter <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            cur_div <= DEFAULT_DIV;
        end else begin
            if (hold) begin
                counter <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else begin
                counter <= wrap ? '0 : counter + ONE;
                clk_out <= (counter < (cur_div >> 1));
                tick    <= wrap;
            end
            if (load) begin
                cur_div <= load_div;
            end
        end
    end
endmodule

// File: rtl/clk_div_controller.sv
// rtl/clk_div_controller.sv - start/stop and glitch-free divisor update control for the divided clock
module clk_div_controller #(
    parameter int               WIDTH       = clk_div_pkg::WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter logic [WIDTH-1:0] MIN_DIV     = clk_div_pkg::MIN_DIV
) (
    input  logic     clkold,
    input  logic     rst,
    clk_div_if.slave bus
);
    import clk_div_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] pend_div;
    logic             stop_req;
    logic             cfg_ready;
    logic             cfg_err;
    logic             running;
    logic             xfer;
    logic             legal;
    logic             wrap;
    logic             load;
    logic [WIDTH-1:0] load_div;
    logic [WIDTH-1:0] cur_div;
    logic             clk_out;
    logic             tick;

    assign xfer  = bus.cfg_valid && cfg_ready;
    assign legal = xfer && (bus.cfg_div >= MIN_DIV);

    // Divisor changes only while idle or on the wrap edge, never mid-period
    always_comb begin
        load     = 1'b0;
        load_div = bus.cfg_div;
        case (state)
            IDLE: load = legal;
            RUN:  load = legal && wrap && stop_req;
            PEND: begin
                load     = wrap;
                load_div = pend_div;
            end
            default: load = 1'b0;
        endcase
    end

    clk_div_core #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clkold   (clkold),
        .rst      (rst),
        .hold     (state == IDLE),
        .load     (load),
        .load_div (load_div),
        .wrap     (wrap),
        .clk_out  (clk_out),
        .tick     (tick),
        .cur_div  (cur_div)
    );

    always_ff @(posedge clkold or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend_div  <= '0;
            stop_req  <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            running   <= 1'b0;
        end else begin
            cfg_err <= xfer && !legal;
            case (state)
                IDLE: begin
                    stop_req <= 1'b0;
                    if (bus.en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    stop_req <= !bus.en;
                    if (wrap && stop_req) begin
                        state    <= IDLE;
                        running  <= 1'b0;
                        stop_req <= 1'b0;
                    end else if (legal) begin
                        pend_div  <= bus.cfg_div;
                        cfg_ready <= 1'b0;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    stop_req <= !bus.en;
                    if (wrap) begin
                        cfg_ready <= 1'b1;
                        if (stop_req) begin
                            state    <= IDLE;
                            running  <= 1'b0;
                            stop_req <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.cfg_err   = cfg_err;
    assign bus.clk_out   = clk_out;
    assign bus.tick      = tick;
    assign bus.running   = running;
    assign bus.cur_div   = cur_div;
endmodule

// File: doc/clk_div_controller.md
Name: clk_div_controller

Overview:
- Run-time controller for the on-board divided-clock generator.
- Starts and stops the divided clock cleanly, accepting only whole periods.
- Accepts new divisor values over a valid/ready handshake and applies them only at a period boundary, so the divided clock never glitches.
- Sits between the system clock domain's control logic (UART/display timing, debouncers) and the slow clock / tick consumers.

Parameters:
- WIDTH, 28, width of the counter and divisor.
- DEFAULT_DIV, 28'd1000, divisor loaded at reset.
- MIN_DIV, 28'd2, smallest legal divisor; smaller requests are rejected.

Ports:
- clkold  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  divisor update request.
- cfg_div  in  WIDTH  requested divisor.
- cfg_ready  out  1  controller can accept an update.
- cfg_err  out  1  one-cycle pulse: accepted request was illegal and discarded.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle strobe per completed period.
- running  out  1  high in RUN or PEND.
- cur_div  out  WIDTH  divisor currently in force.

Behaviour:
- Reset values (asynchronous, rst=1): state IDLE, counter 0, cur_div DEFAULT_DIV, pend_div 0, stop_req 0, clk_out 0, tick 0, cfg_ready 1, cfg_err 0, running 0. Any pending update is discarded. A reset mid-period truncates that period with no tick.
- Handshake: a transfer occurs when cfg_valid && cfg_ready. cfg_valid may be held; no transfer happens while cfg_ready=0.
- Legality: cfg_div < MIN_DIV → cfg_err=1 on the next cycle; no state change; cfg_ready stays 1.
- Wrap condition: counter >= cur_div-1. At wrap, counter goes to 0 on the next edge; otherwise counter increments by 1.
- clk_out <= (counter < cur_div/2), evaluated on the pre-update counter, giving one cycle of latency. Integer division, so high time = floor(div/2) cycles and low time = div - floor(div/2). Example: div 5 → high 2, low 3.
- tick <= 1 on the edge where wrap is true.
- IDLE:
  - counter held at 0; clk_out 0.
  - A legal transfer loads cur_div directly on the next edge.
  - en=1 → RUN. The first period starts at counter 0 and uses the cur_div in force on that edge. A same-cycle legal transfer is used from the first period.
- RUN:
  - Counts as above.
  - A legal transfer stores pend_div, cfg_ready → 0, state → PEND.
  - A transfer in the same cycle as a wrap still goes to PEND. The old divisor governs one more full period.
- PEND:
  - Counts with the old cur_div.
  - At wrap: cur_div <= pend_div, counter 0, cfg_ready → 1, state → RUN (or IDLE if stopping).
- Stop:
  - en=0 in RUN or PEND sets stop_req.
  - The current period finishes; at wrap the state goes to IDLE and running → 0.
  - en re-asserted before that wrap clears stop_req and counting continues seamlessly.
- running = (state != IDLE), registered with the state.

Decomposition:
- Package clk_div_pkg: state enumeration (IDLE, RUN, PEND), WIDTH, DEFAULT_DIV, MIN_DIV.
- Sub-module clk_div_core: counter, wrap compare, clk_out/tick registers, with hold (IDLE) and synchronous load (cur_div) inputs.
- The controller FSM and handshake stay in clk_div_controller.

Test Plan:
1. Reset, then en=1 with DEFAULT_DIV=1000 → clk_out high for 500 cycles and low for 500, repeating; tick once per 1000 cycles; running=1 one edge after en.
2. In RUN, div 1000, counter=300: transfer cfg_div=10 → cfg_ready=0 until the wrap at count 999; then cur_div=10; clk_out 5 high / 5 low; cfg_ready=1.
3. cfg_div=1 in RUN → cfg_err pulses one cycle; cur_div unchanged at 1000; period unaffected.
4. div 6, drop en at counter 2 → two more ticks do not occur; exactly one tick at count 5, then IDLE with clk_out 0. Re-raise en at counter 4 in a second run → no stop, continuous periods.
5. Transfer cfg_div=4 exactly on the wrap cycle, old div 8 → one more 8-cycle period, then 4-cycle periods (2 high / 2 low).
6. Assert rst mid-PEND (pend_div=20) → all outputs take reset values immediately; after release cur_div=1000, cfg_ready=1, and the pending 20 is never applied.
